// File: rtl/pc_stack_sequencer_pkg.sv
// Shared definitions for the call/return stack sequencer: widths, PC/byte types, stack
// address type, default stack placement and the sequencer state encoding.
package pc_stack_sequencer_pkg;

  localparam int unsigned STACK_ADDR_W        = 16;
  localparam int unsigned PC_W                = 16;
  localparam int unsigned DEPTH_W             = 8;
  localparam int unsigned STACK_DEPTH_DEFAULT = 128;

  typedef logic [7:0]              BYTE;
  typedef logic [7:0]              PC_HALF;
  typedef logic [PC_W-1:0]         PROGRAM_COUNTER;
  typedef logic [STACK_ADDR_W-1:0] STACK_ADDR;

  localparam STACK_ADDR STACK_TOP_DEFAULT = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PUSH_HI  = 3'd1,
    ST_PUSH_LO  = 3'd2,
    ST_POP_LO   = 3'd3,
    ST_POP_HI   = 3'd4,
    ST_POP_WAIT = 3'd5,
    ST_FINISH   = 3'd6
  } stack_state_e;

endpackage

// File: rtl/pc_stack_sequencer.sv
// Call/return sequencer: pushes a return PC as two bytes onto a downward-growing data-memory
// stack and pops it back through load_unit, tracking SP, frame depth and sticky error flags.
module pc_stack_sequencer
  import pc_stack_sequencer_pkg::*;
#(
  parameter int unsigned        ADDR_W      = STACK_ADDR_W,
  parameter logic [ADDR_W-1:0]  STACK_TOP   = ADDR_W'(STACK_TOP_DEFAULT),
  parameter int unsigned        STACK_DEPTH = STACK_DEPTH_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              call_req,
  input  logic              ret_req,
  input  logic [15:0]       ret_pc,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  output logic              pc_load,
  output logic [7:0]        depth,
  output logic              overflow,
  output logic              underflow
);

  stack_state_e        state_q, state_d;
  logic [ADDR_W-1:0]   sp_q, sp_d;
  logic [DEPTH_W-1:0]  depth_q, depth_d;
  PC_HALF              pc_lo_q, pc_lo_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  BYTE                 mem_wdata_q, mem_wdata_d;
  logic                mem_we_q, mem_we_d;
  logic                mem_re_q, mem_re_d;
  logic                pc_load_q, pc_load_d;
  logic                overflow_q, overflow_d;
  logic                underflow_q, underflow_d;

  // State, counters and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      sp_q        <= STACK_TOP;
      depth_q     <= '0;
      pc_lo_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mem_addr_q  <= STACK_TOP;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
      pc_load_q   <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sp_q        <= sp_d;
      depth_q     <= depth_d;
      pc_lo_q     <= pc_lo_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      mem_re_q    <= mem_re_d;
      pc_load_q   <= pc_load_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Next state plus the output values for the cycle after this edge
  always_comb begin
    state_d     = state_q;
    sp_d        = sp_q;
    depth_d     = depth_q;
    pc_lo_d     = pc_lo_q;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    mem_addr_d  = sp_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;
    mem_re_d    = 1'b0;
    pc_load_d   = 1'b0;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    unique case (state_q)
      ST_IDLE: begin
        // call has priority; a simultaneous ret is dropped
        if (call_req) begin
          if (depth_q == DEPTH_W'(STACK_DEPTH)) begin
            overflow_d = 1'b1;
            done_d     = 1'b1;
          end else begin
            state_d     = ST_PUSH_HI;
            busy_d      = 1'b1;
            mem_we_d    = 1'b1;
            mem_addr_d  = sp_q;
            mem_wdata_d = ret_pc[15:8];
            pc_lo_d     = ret_pc[7:0];
          end
        end else if (ret_req) begin
          if (depth_q == '0) begin
            underflow_d = 1'b1;
            done_d      = 1'b1;
          end else begin
            state_d    = ST_POP_LO;
            busy_d     = 1'b1;
            mem_re_d   = 1'b1;
            mem_addr_d = sp_q + ADDR_W'(1);
          end
        end
      end
      ST_PUSH_HI: begin
        state_d     = ST_PUSH_LO;
        busy_d      = 1'b1;
        mem_we_d    = 1'b1;
        mem_addr_d  = sp_q - ADDR_W'(1);
        mem_wdata_d = pc_lo_q;
      end
      ST_PUSH_LO: begin
        state_d    = ST_IDLE;
        done_d     = 1'b1;
        sp_d       = sp_q - ADDR_W'(2);
        depth_d    = depth_q + DEPTH_W'(1);
        mem_addr_d = sp_q - ADDR_W'(2);
      end
      ST_POP_LO: begin
        // read data for the lower byte lands on mem_out while pc_load is first high
        state_d    = ST_POP_HI;
        busy_d     = 1'b1;
        mem_re_d   = 1'b1;
        mem_addr_d = sp_q + ADDR_W'(2);
        pc_load_d  = 1'b1;
      end
      ST_POP_HI: begin
        state_d   = ST_POP_WAIT;
        busy_d    = 1'b1;
        pc_load_d = 1'b1;
      end
      ST_POP_WAIT: begin
        state_d    = ST_IDLE;
        done_d     = 1'b1;
        sp_d       = sp_q + ADDR_W'(2);
        depth_d    = depth_q - DEPTH_W'(1);
        mem_addr_d = sp_q + ADDR_W'(2);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;
  assign mem_re    = mem_re_q;
  assign pc_load   = pc_load_q;
  assign depth     = depth_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_pc_stack_sequencer.sv
// Bench for pc_stack_sequencer with a 1-cycle sync-read byte RAM and a load_unit model.
module tb_pc_stack_sequencer;

  logic        clk;
  logic        reset;
  logic        call_req;
  logic        ret_req;
  logic [15:0] ret_pc;
  logic        busy;
  logic        done;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic        mem_re;
  logic        pc_load;
  logic [7:0]  depth;
  logic        overflow;
  logic        underflow;

  logic [7:0]  ram [0:65535];
  logic [7:0]  mem_out;
  logic [15:0] pc_loaded;

  int n_chk  = 0;
  int n_fail = 0;
  int pl_run = 0;

  pc_stack_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .call_req  (call_req),
    .ret_req   (ret_req),
    .ret_pc    (ret_pc),
    .busy      (busy),
    .done      (done),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_re    (mem_re),
    .pc_load   (pc_load),
    .depth     (depth),
    .overflow  (overflow),
    .underflow (underflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Byte RAM with synchronous read
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    if (mem_re) mem_out <= ram[mem_addr];
  end

  // load_unit: lower byte first, then upper
  always @(posedge clk) begin
    if (pc_load) pc_loaded <= {mem_out, pc_loaded[15:8]};
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Every pc_load burst must be exactly two cycles long
  always @(negedge clk) begin
    if (reset) pl_run = 0;
    else if (pc_load) pl_run++;
    else begin
      if (pl_run != 0) chk("pc_load_run", 32'(pl_run), 32'd2);
      pl_run = 0;
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    call_req = 1'b0;
    ret_req = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Issue one request at the next edge and follow it until done (called at a negedge)
  task automatic do_op(input logic c, input logic r, input logic [15:0] pc,
                       output int lat, output int nw, output int nr, output int npl);
    call_req = c;
    ret_req  = r;
    ret_pc   = pc;
    @(posedge clk);
    @(negedge clk);
    call_req = 1'b0;
    ret_req  = 1'b0;
    lat = 0; nw = 0; nr = 0; npl = 0;
    for (int k = 1; k <= 20; k++) begin
      if (k > 1) @(negedge clk);
      nw  += int'(mem_we);
      nr  += int'(mem_re);
      npl += int'(pc_load);
      if (done) begin
        lat = k;
        break;
      end
    end
    if (lat == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL op_timeout: got no done expected done within 20 cycles");
    end
  endtask

  typedef struct {
    logic        c;
    logic        r;
    logic [15:0] pc;
    int          lat;
    int          nw;
    int          nr;
    int          npl;
    logic [7:0]  dep;
    logic [15:0] sp;
    logic        ovf;
    logic        unf;
    logic [15:0] exp_pc;
  } vec_t;

  vec_t vecs [9];

  initial begin
    int lat, nw, nr, npl, ndone;

    vecs[0] = '{1'b1, 1'b0, 16'h1234, 3, 2, 0, 0, 8'd1, 16'hFFFD, 1'b0, 1'b0, 16'h0000};
    vecs[1] = '{1'b0, 1'b1, 16'h0000, 4, 0, 2, 2, 8'd0, 16'hFFFF, 1'b0, 1'b0, 16'h1234};
    vecs[2] = '{1'b1, 1'b0, 16'h0A0B, 3, 2, 0, 0, 8'd1, 16'hFFFD, 1'b0, 1'b0, 16'h1234};
    vecs[3] = '{1'b1, 1'b0, 16'h0C0D, 3, 2, 0, 0, 8'd2, 16'hFFFB, 1'b0, 1'b0, 16'h1234};
    vecs[4] = '{1'b0, 1'b1, 16'h0000, 4, 0, 2, 2, 8'd1, 16'hFFFD, 1'b0, 1'b0, 16'h0C0D};
    vecs[5] = '{1'b0, 1'b1, 16'h0000, 4, 0, 2, 2, 8'd0, 16'hFFFF, 1'b0, 1'b0, 16'h0A0B};
    vecs[6] = '{1'b0, 1'b1, 16'h0000, 1, 0, 0, 0, 8'd0, 16'hFFFF, 1'b0, 1'b1, 16'h0A0B};
    vecs[7] = '{1'b1, 1'b1, 16'h5566, 3, 2, 0, 0, 8'd1, 16'hFFFD, 1'b0, 1'b1, 16'h0A0B};
    vecs[8] = '{1'b0, 1'b1, 16'h0000, 4, 0, 2, 2, 8'd0, 16'hFFFF, 1'b0, 1'b1, 16'h5566};

    reset = 1'b1; call_req = 1'b0; ret_req = 1'b0; ret_pc = '0; pc_loaded = '0;
    do_reset();

    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_re", 32'(mem_re), 32'd0);
    chk("rst_pc_load", 32'(pc_load), 32'd0);
    chk("rst_depth", 32'(depth), 32'd0);
    chk("rst_flags", 32'({overflow, underflow}), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'hFFFF);
    chk("rst_wdata", 32'(mem_wdata), 32'd0);

    for (int i = 0; i < 9; i++) begin
      do_op(vecs[i].c, vecs[i].r, vecs[i].pc, lat, nw, nr, npl);
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      chk($sformatf("v%0d_writes", i), 32'(nw), 32'(vecs[i].nw));
      chk($sformatf("v%0d_reads", i), 32'(nr), 32'(vecs[i].nr));
      chk($sformatf("v%0d_pc_load_cycles", i), 32'(npl), 32'(vecs[i].npl));
      chk($sformatf("v%0d_depth", i), 32'(depth), 32'(vecs[i].dep));
      chk($sformatf("v%0d_sp", i), 32'(mem_addr), 32'(vecs[i].sp));
      chk($sformatf("v%0d_overflow", i), 32'(overflow), 32'(vecs[i].ovf));
      chk($sformatf("v%0d_underflow", i), 32'(underflow), 32'(vecs[i].unf));
      chk($sformatf("v%0d_pc_loaded", i), 32'(pc_loaded), 32'(vecs[i].exp_pc));
      if (i == 0) begin
        chk("ram_ffff_first", 32'(ram[16'hFFFF]), 32'h12);
        chk("ram_fffe_first", 32'(ram[16'hFFFE]), 32'h34);
      end
    end
    chk("ram_ffff", 32'(ram[16'hFFFF]), 32'h55);
    chk("ram_fffe", 32'(ram[16'hFFFE]), 32'h66);
    chk("ram_fffd", 32'(ram[16'hFFFD]), 32'h0C);
    chk("ram_fffc", 32'(ram[16'hFFFC]), 32'h0D);

    // Fill to 128 frames, then one more call must be refused
    do_reset();
    for (int i = 0; i < 128; i++) do_op(1'b1, 1'b0, 16'(16'hA000 + i), lat, nw, nr, npl);
    chk("full_depth", 32'(depth), 32'd128);
    chk("full_overflow", 32'(overflow), 32'd0);
    do_op(1'b1, 1'b0, 16'hDEAD, lat, nw, nr, npl);
    chk("ovf_latency", 32'(lat), 32'd1);
    chk("ovf_writes", 32'(nw), 32'd0);
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_depth", 32'(depth), 32'd128);
    chk("ovf_sp", 32'(mem_addr), 32'hFEFF);
    do_op(1'b0, 1'b1, 16'h0000, lat, nw, nr, npl);
    chk("ovf_pop_pc", 32'(pc_loaded), 32'hA07F);
    chk("ovf_sticky", 32'(overflow), 32'd1);
    chk("ovf_pop_depth", 32'(depth), 32'd127);

    // call_req held through the busy cycles is not queued
    do_reset();
    call_req = 1'b1;
    ret_pc   = 16'h7777;
    nw = 0;
    ndone = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 2) call_req = 1'b0;
      nw    += int'(mem_we);
      ndone += int'(done);
    end
    chk("busy_req_writes", 32'(nw), 32'd2);
    chk("busy_req_done", 32'(ndone), 32'd1);
    chk("busy_req_depth", 32'(depth), 32'd1);
    chk("busy_req_sp", 32'(mem_addr), 32'hFFFD);

    // Reset in the second cycle of a pop clears everything
    do_reset();
    do_op(1'b0, 1'b1, 16'h0000, lat, nw, nr, npl);
    do_op(1'b1, 1'b0, 16'hBEEF, lat, nw, nr, npl);
    chk("pre_rst_underflow", 32'(underflow), 32'd1);
    ret_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ret_req = 1'b0;
    @(negedge clk);
    chk("pop_c2_pc_load", 32'(pc_load), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_pc_load", 32'(pc_load), 32'd0);
    chk("midrst_re", 32'(mem_re), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_depth", 32'(depth), 32'd0);
    chk("midrst_sp", 32'(mem_addr), 32'hFFFF);
    chk("midrst_flags", 32'({overflow, underflow}), 32'd0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_rst_idle", 32'({busy, done, mem_we, mem_re, pc_load}), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
